// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline results with buffered
// out-of-order multi-cycle results, and tracks registers with outstanding multi-cycle writes.
module wb_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              wb_stall_o,
    input  logic              mc_issue_i,
    input  logic [4:0]        mc_issue_rd_i,
    input  logic              mc_valid_i,
    output logic              mc_ready_o,
    input  logic [4:0]        mc_rd_i,
    input  logic [DATA_W-1:0] mc_data_i,
    output logic              reg_write_en_o,
    output logic [4:0]        rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [31:0]       busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       busy_q, busy_d;
    logic              en_q, en_d;
    logic [4:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic   full, push, pop, take_wb;
    entry_t head;

    // Full/ready derive only from registered count, so no combinational path from the valids.
    assign full       = (count_q == FULL_CNT);
    assign mc_ready_o = !full;
    assign wb_stall_o = full;
    assign push       = mc_valid_i && !full;
    assign pop        = full || (!wb_valid_i && count_q != '0);
    assign take_wb    = !full && wb_valid_i;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        busy_d   = busy_q;
        en_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        if (pop) begin
            en_d   = (head.rd != 5'd0);
            addr_d = head.rd;
            data_d = head.data;
            busy_d[head.rd] = 1'b0;
        end else if (take_wb) begin
            en_d   = (wb_rd_i != 5'd0);
            addr_d = wb_rd_i;
            data_d = wb_data_i;
        end

        // Set after clear: a newly issued op to the same register stays outstanding.
        if (mc_issue_i && mc_issue_rd_i != 5'd0) busy_d[mc_issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // NOTE: FIFO storage is not reset; count gates every read, so stale entries are never used.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{rd: mc_rd_i, data: mc_data_i};
    end

    assign reg_write_en_o = en_q;
    assign rd_addr_o      = addr_q;
    assign rd_data_o      = data_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (DATA_W = 32, DEPTH = 2).
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        wb_stall_o;
    logic        mc_issue_i;
    logic [4:0]  mc_issue_rd_i;
    logic        mc_valid_i;
    logic        mc_ready_o;
    logic [4:0]  mc_rd_i;
    logic [31:0] mc_data_i;
    logic        reg_write_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [31:0] busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_write_arbiter #(.DATA_W(32), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_i        (wb_rd_i),
        .wb_data_i      (wb_data_i),
        .wb_stall_o     (wb_stall_o),
        .mc_issue_i     (mc_issue_i),
        .mc_issue_rd_i  (mc_issue_rd_i),
        .mc_valid_i     (mc_valid_i),
        .mc_ready_o     (mc_ready_o),
        .mc_rd_i        (mc_rd_i),
        .mc_data_i      (mc_data_i),
        .reg_write_en_o (reg_write_en_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_o      (rd_data_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
        mc_issue_i = 1'b0; mc_issue_rd_i = '0;
        mc_valid_i = 1'b0; mc_rd_i = '0; mc_data_i = '0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_valid_i = 1'b1; wb_rd_i = rd; wb_data_i = d;
    endtask

    task automatic mc(input logic [4:0] rd, input logic [31:0] d);
        mc_valid_i = 1'b1; mc_rd_i = rd; mc_data_i = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        mc_issue_i = 1'b1; mc_issue_rd_i = rd;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] rd, input logic [31:0] d);
        check({tag, ".en"},   32'(reg_write_en_o), 32'd1);
        check({tag, ".addr"}, 32'(rd_addr_o), 32'(rd));
        check({tag, ".data"}, rd_data_o, d);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check("rst.en",    32'(reg_write_en_o), 32'd0);
        check("rst.addr",  32'(rd_addr_o), 32'd0);
        check("rst.data",  rd_data_o, 32'd0);
        check("rst.busy",  busy_o, 32'd0);
        check("rst.ready", 32'(mc_ready_o), 32'd1);
        check("rst.stall", 32'(wb_stall_o), 32'd0);
        tick();
        check("idle.en", 32'(reg_write_en_o), 32'd0);

        // Pipeline only; rd = 0 consumed but no write
        wb(5, 32'hDEADBEEF); tick(); idle();
        expect_write("pipe", 5, 32'hDEADBEEF);
        wb(0, 32'h0000_1234); tick(); idle();
        check("pipe_x0.en",   32'(reg_write_en_o), 32'd0);
        check("pipe_x0.addr", 32'(rd_addr_o), 32'd0);
        tick();
        check("hold.en",   32'(reg_write_en_o), 32'd0);
        check("hold.data", rd_data_o, 32'h0000_1234);

        // Collision: pipeline wins, FIFO result follows, busy clears with the x7 write
        issue(7); tick(); idle();
        check("coll.busy_set", busy_o, 32'h0000_0080);
        mc(7, 32'h11); wb(3, 32'h22); tick(); idle();
        expect_write("coll.n1", 3, 32'h22);
        check("coll.busy_n1", busy_o, 32'h0000_0080);
        tick();
        expect_write("coll.n2", 7, 32'h11);
        check("coll.busy_n2", busy_o, 32'h0);
        tick();
        check("coll.after.en", 32'(reg_write_en_o), 32'd0);

        // FIFO full: fill with 8, 9 while pipeline keeps flowing
        mc(8, 32'h88); wb(1, 32'h01); tick();
        expect_write("full.c1", 1, 32'h01);
        check("full.c1.ready", 32'(mc_ready_o), 32'd1);
        mc(9, 32'h99); wb(2, 32'h02); tick();
        expect_write("full.c2", 2, 32'h02);
        check("full.ready", 32'(mc_ready_o), 32'd0);
        check("full.stall", 32'(wb_stall_o), 32'd1);
        // Protocol violation attempt: x13 must not be pushed while full
        mc(13, 32'hDD); wb(4, 32'h44); tick();
        mc_valid_i = 1'b0;
        expect_write("full.x8", 8, 32'h88);
        check("full.stall_rel", 32'(wb_stall_o), 32'd0);
        tick(); idle();
        expect_write("full.x4", 4, 32'h44);
        tick();
        expect_write("full.x9", 9, 32'h99);
        tick();
        check("full.drained.en", 32'(reg_write_en_o), 32'd0);
        check("full.drained.ready", 32'(mc_ready_o), 32'd1);

        // Scoreboard race: pop of x10 and new issue of x10 in the same cycle
        issue(10); tick(); idle();
        check("race.busy_set", busy_o, 32'h0000_0400);
        mc(10, 32'hA0); tick(); idle();
        issue(10); tick(); idle();
        expect_write("race.pop", 10, 32'hA0);
        check("race.busy_kept", busy_o, 32'h0000_0400);
        mc(10, 32'hA1); tick(); idle();
        tick();
        expect_write("race.pop2", 10, 32'hA1);
        check("race.busy_clr", busy_o, 32'h0);
        issue(0); tick(); idle();
        check("busy.x0", busy_o, 32'h0);

        // Reset mid-operation with a full FIFO and busy bits set
        issue(11); tick(); issue(12); tick(); idle();
        check("mid.busy", busy_o, 32'h0000_1800);
        mc(11, 32'hB1); wb(1, 32'h01); tick();
        mc(12, 32'hB2); wb(2, 32'h02); tick(); idle();
        check("mid.full", 32'(wb_stall_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid.rst.en",    32'(reg_write_en_o), 32'd0);
        check("mid.rst.addr",  32'(rd_addr_o), 32'd0);
        check("mid.rst.data",  rd_data_o, 32'd0);
        check("mid.rst.busy",  busy_o, 32'd0);
        check("mid.rst.ready", 32'(mc_ready_o), 32'd1);
        check("mid.rst.stall", 32'(wb_stall_o), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid.post%0d.en", i), 32'(reg_write_en_o), 32'd0);
        end
        check("mid.post.busy", busy_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
